// File: rtl/io_stage_pkg.sv
// Shared type definitions for the memory-response (IO) stage.
//   cpu_core_params  : core data widths and load_type encodings
//   exe_stage_params : EXE -> IO pipeline bus
//   io_stage_params  : IO -> WB bus, IO -> ID back-pass bus, response FSM states
package cpu_core_params;
  typedef logic [31:0] CpuData;
  typedef logic [31:0] ProgramCount;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LBU = 3'd1;
  localparam logic [2:0] LH  = 3'd2;
  localparam logic [2:0] LHU = 3'd3;
  localparam logic [2:0] LW  = 3'd4;
  localparam logic [2:0] LWL = 3'd5;
  localparam logic [2:0] LWR = 3'd6;
endpackage

package exe_stage_params;
  import cpu_core_params::*;

  typedef struct packed {
    logic        valid;
    ProgramCount program_count;
    logic        register_file_write_enabled;
    logic [4:0]  register_file_address;
    logic        memory_read;
    logic [2:0]  load_type;
    logic [1:0]  address_low;
    CpuData      alu_result;
    CpuData      rt_value;
  } EXEToIOData;
endpackage

package io_stage_params;
  import cpu_core_params::*;

  typedef struct packed {
    logic        valid;
    ProgramCount program_count;
    logic        register_file_write_enabled;
    logic [4:0]  register_file_address;
    logic [3:0]  register_file_write_strobe;
    CpuData      final_result;
  } IOToWBData;

  typedef struct packed {
    logic       valid;
    logic       data_pending;
    logic [4:0] write_register;
    logic [3:0] write_strobe;
    CpuData     write_data;
  } IOToIDBackPassData;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } IoRespState;
endpackage

// File: rtl/io_stage_load_aligner.sv
// load_aligner: combinational extraction/alignment of load data.
//   load_data   : raw 32-bit word from the data SRAM (or the response buffer)
//   address_low : byte offset of the load address
//   load_type   : LB/LBU/LH/LHU/LW/LWL/LWR encoding
//   final_data  : aligned, extended value to write back
//   strobe      : byte lanes of the destination register to update
module load_aligner
  import cpu_core_params::*;
(
  input  CpuData     load_data,
  input  logic [1:0] address_low,
  input  logic [2:0] load_type,
  output CpuData     final_data,
  output logic [3:0] strobe
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  assign byte_val  = load_data[{address_low, 3'b000} +: 8];
  assign half_val  = address_low[1] ? load_data[31:16] : load_data[15:0];
  assign lwl_shift = {2'd3 - address_low, 3'b000};
  assign lwr_shift = {address_low, 3'b000};

  always_comb begin
    final_data = load_data;
    strobe     = 4'b1111;
    case (load_type)
      LB:  final_data = {{24{byte_val[7]}}, byte_val};
      LBU: final_data = {24'd0, byte_val};
      LH:  final_data = {{16{half_val[15]}}, half_val};
      LHU: final_data = {16'd0, half_val};
      LW:  final_data = load_data;
      // Unaligned pair: only the lanes covered by this access are written,
      // WB merges the rest from the old register value.
      LWL: begin
        final_data = load_data << lwl_shift;
        strobe     = 4'b1111 << (2'd3 - address_low);
      end
      LWR: begin
        final_data = load_data >> lwr_shift;
        strobe     = 4'b1111 >> address_low;
      end
      default: begin
        final_data = load_data;
        strobe     = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/io_stage.sv
// io_stage: memory-response stage of the 5-stage MIPS pipeline.
// Holds one instruction from EXE, waits for the data-SRAM response of a load,
// aligns the load data and forwards the result to WB and back to ID.
//   clock, reset            : clock, synchronous active-high reset
//   io_allow_in             : IO can accept an EXE instruction this cycle
//   exe_to_io_bus           : instruction from EXE
//   wb_allow_in             : WB can accept an instruction
//   io_to_wb_bus            : result, strobe and destination to WB
//   io_to_id_back_pass_bus  : forwarding / stall information for ID
//   data_sram_data_ok       : one response per issued load
//   data_sram_rdata         : response read data
//
// state | meaning
// IDLE  | no response owed to the instruction in IO
// WAIT  | load in IO, response not yet returned
// HOLD  | response returned while WB stalled; data held in resp_buffer
module io_stage
  import cpu_core_params::*;
  import exe_stage_params::*;
  import io_stage_params::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic              io_allow_in,
  input  EXEToIOData        exe_to_io_bus,
  input  logic              wb_allow_in,
  output IOToWBData         io_to_wb_bus,
  output IOToIDBackPassData io_to_id_back_pass_bus,
  input  logic              data_sram_data_ok,
  input  CpuData            data_sram_rdata
);

  logic       io_valid;
  EXEToIOData io_data;
  IoRespState state;
  CpuData     resp_buffer;

  logic       io_ready_go;
  logic       capture;
  logic       capture_load;
  CpuData     load_data;
  CpuData     aligned_data;
  logic [3:0] aligned_strobe;
  CpuData     final_result;
  logic [3:0] write_strobe;
  logic       unused_payload;

  assign io_ready_go  = !io_data.memory_read || (state == HOLD)
                        || (state == WAIT && data_sram_data_ok);
  assign io_allow_in  = !io_valid || (io_ready_go && wb_allow_in);
  assign capture      = io_allow_in && exe_to_io_bus.valid;
  assign capture_load = capture && exe_to_io_bus.memory_read;

  always_ff @(posedge clock) begin
    if (capture) io_data <= exe_to_io_bus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_valid    <= 1'b0;
      state       <= IDLE;
      resp_buffer <= '0;
    end else begin
      if (io_allow_in) io_valid <= exe_to_io_bus.valid;
      case (state)
        IDLE: if (capture_load) state <= WAIT;
        WAIT: begin
          if (data_sram_data_ok) begin
            if (wb_allow_in) begin
              state <= capture_load ? WAIT : IDLE;
            end else begin
              state       <= HOLD;
              resp_buffer <= data_sram_rdata;
            end
          end
        end
        HOLD: if (wb_allow_in) state <= capture_load ? WAIT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The SRAM only presents rdata in the data_ok cycle, so a stalled response
  // has to come from the buffer.
  assign load_data = (state == HOLD) ? resp_buffer : data_sram_rdata;

  load_aligner u_load_aligner (
    .load_data   (load_data),
    .address_low (io_data.address_low),
    .load_type   (io_data.load_type),
    .final_data  (aligned_data),
    .strobe      (aligned_strobe)
  );

  assign final_result = io_data.memory_read ? aligned_data : io_data.alu_result;
  assign write_strobe = !io_data.register_file_write_enabled ? 4'b0000
                        : (io_data.memory_read ? aligned_strobe : 4'b1111);

  assign io_to_wb_bus.valid                       = io_valid && io_ready_go;
  assign io_to_wb_bus.program_count               = io_data.program_count;
  assign io_to_wb_bus.register_file_write_enabled = io_data.register_file_write_enabled;
  assign io_to_wb_bus.register_file_address       = io_data.register_file_address;
  assign io_to_wb_bus.register_file_write_strobe  = write_strobe;
  assign io_to_wb_bus.final_result                = final_result;

  assign io_to_id_back_pass_bus.valid =
    io_valid && io_data.register_file_write_enabled;
  assign io_to_id_back_pass_bus.data_pending =
    io_to_id_back_pass_bus.valid && io_data.memory_read && !io_ready_go;
  assign io_to_id_back_pass_bus.write_register = io_data.register_file_address;
  assign io_to_id_back_pass_bus.write_strobe   = write_strobe;
  assign io_to_id_back_pass_bus.write_data     = final_result;

  // rt_value is merged in WB, and the captured valid is tracked by io_valid.
  assign unused_payload = ^{io_data.rt_value, io_data.valid};

endmodule

// File: tb/tb_io_stage.sv
module tb_io_stage;
  import cpu_core_params::*;
  import exe_stage_params::*;
  import io_stage_params::*;

  logic              clock;
  logic              reset;
  logic              io_allow_in;
  EXEToIOData        exe_to_io_bus;
  logic              wb_allow_in;
  IOToWBData         io_to_wb_bus;
  IOToIDBackPassData io_to_id_back_pass_bus;
  logic              data_sram_data_ok;
  CpuData            data_sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  io_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_allow_in            (io_allow_in),
    .exe_to_io_bus          (exe_to_io_bus),
    .wb_allow_in            (wb_allow_in),
    .io_to_wb_bus           (io_to_wb_bus),
    .io_to_id_back_pass_bus (io_to_id_back_pass_bus),
    .data_sram_data_ok      (data_sram_data_ok),
    .data_sram_rdata        (data_sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_exe(input logic v, input logic mr, input logic [2:0] lt,
                         input logic [1:0] al, input logic [31:0] alu, input logic we);
    exe_to_io_bus = '0;
    exe_to_io_bus.valid                       = v;
    exe_to_io_bus.program_count               = 32'hBFC0_0100;
    exe_to_io_bus.register_file_write_enabled = we;
    exe_to_io_bus.register_file_address       = 5'd7;
    exe_to_io_bus.memory_read                 = mr;
    exe_to_io_bus.load_type                   = lt;
    exe_to_io_bus.address_low                 = al;
    exe_to_io_bus.alu_result                  = alu;
    exe_to_io_bus.rt_value                    = 32'h0BAD_0BAD;
  endtask

  // Load captured, response in the following cycle with WB ready.
  task automatic run_load(input string tag, input logic [2:0] lt, input logic [1:0] al,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic [3:0] exp_strobe);
    set_exe(1'b1, 1'b1, lt, al, {30'h400, al}, 1'b1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    check_eq({tag, "_valid"},  32'(io_to_wb_bus.valid), 32'd1);
    check_eq({tag, "_data"},   io_to_wb_bus.final_result, exp_data);
    check_eq({tag, "_strobe"}, 32'(io_to_wb_bus.register_file_write_strobe), 32'(exp_strobe));
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
  endtask

  initial begin
    reset             = 1'b1;
    wb_allow_in       = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    tick();
    tick();
    check_eq("rst_io_valid", 32'(dut.io_valid), 32'd0);
    check_eq("rst_state",    32'(dut.state), 32'(IDLE));
    check_eq("rst_allow_in", 32'(io_allow_in), 32'd1);
    check_eq("rst_wb_valid", 32'(io_to_wb_bus.valid), 32'd0);
    check_eq("rst_bp_valid", 32'(io_to_id_back_pass_bus.valid), 32'd0);
    reset = 1'b0;
    tick();

    // LW: result visible in the response cycle, IO ready for the next instruction.
    set_exe(1'b1, 1'b1, LW, 2'd0, 32'h0000_1004, 1'b1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    check_eq("lw_wait_state",   32'(dut.state), 32'(WAIT));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8899_AABB;
    #1;
    check_eq("lw_valid",    32'(io_to_wb_bus.valid), 32'd1);
    check_eq("lw_data",     io_to_wb_bus.final_result, 32'h8899_AABB);
    check_eq("lw_strobe",   32'(io_to_wb_bus.register_file_write_strobe), 32'hF);
    check_eq("lw_allow_in", 32'(io_allow_in), 32'd1);
    check_eq("lw_pc",       io_to_wb_bus.program_count, 32'hBFC0_0100);
    check_eq("lw_pending",  32'(io_to_id_back_pass_bus.data_pending), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    check_eq("lw_idle_state", 32'(dut.state), 32'(IDLE));
    check_eq("lw_idle_valid", 32'(io_to_wb_bus.valid), 32'd0);

    run_load("lb_a3",  LB,  2'd3, 32'h8011_2233, 32'hFFFF_FF80, 4'hF);
    run_load("lbu_a3", LBU, 2'd3, 32'h8011_2233, 32'h0000_0080, 4'hF);
    run_load("lb_a1",  LB,  2'd1, 32'h8011_2233, 32'h0000_0022, 4'hF);
    run_load("lhu_a2", LHU, 2'd2, 32'hF00D_1234, 32'h0000_F00D, 4'hF);
    run_load("lh_a2",  LH,  2'd2, 32'hF00D_1234, 32'hFFFF_F00D, 4'hF);
    run_load("lh_a0",  LH,  2'd0, 32'hF00D_1234, 32'h0000_1234, 4'hF);
    run_load("lwl_a1", LWL, 2'd1, 32'h1122_3344, 32'h3344_0000, 4'hC);
    run_load("lwl_a0", LWL, 2'd0, 32'h1122_3344, 32'h4400_0000, 4'h8);
    run_load("lwl_a3", LWL, 2'd3, 32'h1122_3344, 32'h1122_3344, 4'hF);
    run_load("lwr_a2", LWR, 2'd2, 32'h1122_3344, 32'h0000_1122, 4'h3);
    run_load("lwr_a0", LWR, 2'd0, 32'h1122_3344, 32'h1122_3344, 4'hF);
    run_load("lwr_a3", LWR, 2'd3, 32'h1122_3344, 32'h0000_0011, 4'h1);

    // Slow response: three stall cycles before data_ok.
    set_exe(1'b1, 1'b1, LW, 2'd0, 32'h0000_2000, 1'b1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("slow_valid_%0d", i),   32'(io_to_wb_bus.valid), 32'd0);
      check_eq($sformatf("slow_pending_%0d", i), 32'(io_to_id_back_pass_bus.data_pending), 32'd1);
      check_eq($sformatf("slow_allow_%0d", i),   32'(io_allow_in), 32'd0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    #1;
    check_eq("slow_done_valid",   32'(io_to_wb_bus.valid), 32'd1);
    check_eq("slow_done_data",    io_to_wb_bus.final_result, 32'hCAFE_F00D);
    check_eq("slow_done_pending", 32'(io_to_id_back_pass_bus.data_pending), 32'd0);
    check_eq("slow_bp_data",      io_to_id_back_pass_bus.write_data, 32'hCAFE_F00D);
    tick();
    data_sram_data_ok = 1'b0;

    // Response while WB stalls: held in the buffer across rdata changes.
    set_exe(1'b1, 1'b1, LW, 2'd0, 32'h0000_3000, 1'b1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    wb_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check_eq("hold_resp_allow", 32'(io_allow_in), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    check_eq("hold_state",  32'(dut.state), 32'(HOLD));
    check_eq("hold_data",   io_to_wb_bus.final_result, 32'hDEAD_BEEF);
    check_eq("hold_allow",  32'(io_allow_in), 32'd0);
    tick();
    check_eq("hold_data_2", io_to_wb_bus.final_result, 32'hDEAD_BEEF);
    wb_allow_in = 1'b1;
    #1;
    check_eq("hold_rel_valid", 32'(io_to_wb_bus.valid), 32'd1);
    check_eq("hold_rel_data",  io_to_wb_bus.final_result, 32'hDEAD_BEEF);
    check_eq("hold_rel_allow", 32'(io_allow_in), 32'd1);
    tick();
    check_eq("hold_rel_state", 32'(dut.state), 32'(IDLE));

    // Back-to-back loads with single-cycle responses.
    set_exe(1'b1, 1'b1, LW, 2'd0, 32'h0000_4000, 1'b1);
    tick();
    set_exe(1'b1, 1'b1, LBU, 2'd1, 32'h0000_4005, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_0001;
    #1;
    check_eq("b2b_a_data",  io_to_wb_bus.final_result, 32'hAAAA_0001);
    check_eq("b2b_a_allow", 32'(io_allow_in), 32'd1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    data_sram_rdata = 32'h0000_5A00;
    #1;
    check_eq("b2b_b_state", 32'(dut.state), 32'(WAIT));
    check_eq("b2b_b_valid", 32'(io_to_wb_bus.valid), 32'd1);
    check_eq("b2b_b_data",  io_to_wb_bus.final_result, 32'h0000_005A);
    tick();
    data_sram_data_ok = 1'b0;
    check_eq("b2b_idle", 32'(dut.state), 32'(IDLE));

    // ALU results pass through; strobe gated when no register write.
    set_exe(1'b1, 1'b0, LB, 2'd3, 32'h1357_9BDF, 1'b1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    #1;
    check_eq("alu_valid",  32'(io_to_wb_bus.valid), 32'd1);
    check_eq("alu_data",   io_to_wb_bus.final_result, 32'h1357_9BDF);
    check_eq("alu_strobe", 32'(io_to_wb_bus.register_file_write_strobe), 32'hF);
    check_eq("alu_bp_reg", 32'(io_to_id_back_pass_bus.write_register), 32'd7);
    check_eq("alu_bp_valid", 32'(io_to_id_back_pass_bus.valid), 32'd1);
    tick();
    set_exe(1'b1, 1'b0, LW, 2'd0, 32'h2468_ACE0, 1'b0);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    #1;
    check_eq("nowe_strobe",   32'(io_to_wb_bus.register_file_write_strobe), 32'h0);
    check_eq("nowe_bp_valid", 32'(io_to_id_back_pass_bus.valid), 32'd0);
    tick();

    // Reset while a load waits; a stray response afterwards is ignored.
    set_exe(1'b1, 1'b1, LW, 2'd0, 32'h0000_6000, 1'b1);
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    check_eq("rstw_state_before", 32'(dut.state), 32'(WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rstw_io_valid", 32'(dut.io_valid), 32'd0);
    check_eq("rstw_state",    32'(dut.state), 32'(IDLE));
    check_eq("rstw_buffer",   dut.resp_buffer, 32'h0);
    set_exe(1'b1, 1'b0, LW, 2'd0, 32'h0000_55AA, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_BAD0;
    tick();
    set_exe(1'b0, 1'b0, LW, 2'd0, 32'd0, 1'b0);
    data_sram_data_ok = 1'b0;
    #1;
    check_eq("rstw_alu_state", 32'(dut.state), 32'(IDLE));
    check_eq("rstw_alu_valid", 32'(io_to_wb_bus.valid), 32'd1);
    check_eq("rstw_alu_data",  io_to_wb_bus.final_result, 32'h0000_55AA);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
